// File: rtl/bp_common_pkg.sv
// Shared types for the sacc vector-dot-product sequencer: CSR indices and
// controller FSM states.
package bp_common_pkg;

   typedef enum logic [2:0] {
      e_sacc_vdp_csr_a_base   = 3'd0,
      e_sacc_vdp_csr_b_base   = 3'd1,
      e_sacc_vdp_csr_len      = 3'd2,
      e_sacc_vdp_csr_res_addr = 3'd3,
      e_sacc_vdp_csr_start    = 3'd4,
      e_sacc_vdp_csr_status   = 3'd5,
      e_sacc_vdp_csr_result   = 3'd6
   } bp_sacc_vdp_csr_e;

   typedef enum logic [2:0] {
      e_vdp_idle   = 3'd0,
      e_vdp_rd_a   = 3'd1,
      e_vdp_wt_a   = 3'd2,
      e_vdp_rd_b   = 3'd3,
      e_vdp_wt_b   = 3'd4,
      e_vdp_wr_res = 3'd5,
      e_vdp_wt_wr  = 3'd6
   } e_sacc_vdp_ctrl_state_e;

endpackage

// File: rtl/bp_sacc_vdp_csr_regfile.sv
// CSR storage and one-entry response buffer for the vector-dot-product
// sequencer. Configuration writes and START are ignored while busy.
module bp_sacc_vdp_csr_regfile
   import bp_common_pkg::*;
#(
   parameter int paddr_width_p    = 40,
   parameter int data_width_p     = 64,
   parameter int len_width_p      = 16,
   parameter int csr_addr_width_p = 3
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        csr_v_i,
   input  logic                        csr_w_i,
   input  logic [csr_addr_width_p-1:0] csr_addr_i,
   input  logic [data_width_p-1:0]     csr_data_i,
   output logic                        csr_ready_o,
   output logic                        csr_resp_v_o,
   output logic [data_width_p-1:0]     csr_resp_data_o,
   input  logic                        csr_resp_yumi_i,
   input  logic                        busy_i,
   input  logic                        done_set_i,
   input  logic [data_width_p-1:0]     result_i,
   output logic [paddr_width_p-1:0]    a_base_o,
   output logic [paddr_width_p-1:0]    b_base_o,
   output logic [len_width_p-1:0]      len_o,
   output logic [paddr_width_p-1:0]    res_addr_o,
   output logic                        start_o
);

   logic [data_width_p-1:0] a_base_q, b_base_q, res_addr_q, result_q, rd_data;
   logic [len_width_p-1:0]  len_q;
   logic                    done_q, accept, wr_en;
   logic [2:0]              csr_idx;

   // Handshake: a request is accepted when csr_v_i & csr_ready_o; the
   // response is held in one buffer until csr_resp_yumi_i, and no new
   // request is accepted while it is held.
   assign csr_idx     = csr_addr_i[2:0];
   assign csr_ready_o = ~csr_resp_v_o;
   assign accept      = csr_v_i & csr_ready_o;
   assign wr_en       = accept & csr_w_i & ~busy_i;
   assign start_o     = wr_en & (csr_idx == e_sacc_vdp_csr_start);

   assign a_base_o   = a_base_q[paddr_width_p-1:0];
   assign b_base_o   = b_base_q[paddr_width_p-1:0];
   assign res_addr_o = res_addr_q[paddr_width_p-1:0];
   assign len_o      = len_q;

   always_comb begin
      rd_data = '0;
      case (csr_idx)
         e_sacc_vdp_csr_a_base:   rd_data = a_base_q;
         e_sacc_vdp_csr_b_base:   rd_data = b_base_q;
         e_sacc_vdp_csr_len:      rd_data = data_width_p'(len_q);
         e_sacc_vdp_csr_res_addr: rd_data = res_addr_q;
         e_sacc_vdp_csr_status:   rd_data = {{(data_width_p-2){1'b0}}, done_q, busy_i};
         e_sacc_vdp_csr_result:   rd_data = result_q;
         default:                 rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         csr_resp_v_o    <= 1'b0;
         csr_resp_data_o <= '0;
         a_base_q        <= '0;
         b_base_q        <= '0;
         len_q           <= '0;
         res_addr_q      <= '0;
         result_q        <= '0;
         done_q          <= 1'b0;
      end else begin
         if (accept) begin
            csr_resp_v_o    <= 1'b1;
            csr_resp_data_o <= csr_w_i ? '0 : rd_data;
         end else if (csr_resp_yumi_i) begin
            csr_resp_v_o <= 1'b0;
         end
         if (wr_en) begin
            case (csr_idx)
               e_sacc_vdp_csr_a_base:   a_base_q   <= csr_data_i;
               e_sacc_vdp_csr_b_base:   b_base_q   <= csr_data_i;
               e_sacc_vdp_csr_len:      len_q      <= csr_data_i[len_width_p-1:0];
               e_sacc_vdp_csr_res_addr: res_addr_q <= csr_data_i;
               default: ;
            endcase
         end
         if (start_o) begin
            done_q <= 1'b0;
         end else if (done_set_i) begin
            done_q   <= 1'b1;
            result_q <= result_i;
         end
      end
   end

endmodule

// File: rtl/bp_sacc_vdp_ctrl.sv
// Vector-dot-product sequencer: fetches A/B elements over the I/O channel,
// multiply-accumulates them and stores the result to RES_ADDR.
module bp_sacc_vdp_ctrl
   import bp_common_pkg::*;
#(
   parameter int paddr_width_p    = 40,
   parameter int data_width_p     = 64,
   parameter int len_width_p      = 16,
   parameter int csr_addr_width_p = 3
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        csr_v_i,
   input  logic                        csr_w_i,
   input  logic [csr_addr_width_p-1:0] csr_addr_i,
   input  logic [data_width_p-1:0]     csr_data_i,
   output logic                        csr_ready_o,
   output logic                        csr_resp_v_o,
   output logic [data_width_p-1:0]     csr_resp_data_o,
   input  logic                        csr_resp_yumi_i,
   output logic                        mem_cmd_v_o,
   output logic                        mem_cmd_w_o,
   output logic [paddr_width_p-1:0]    mem_cmd_addr_o,
   output logic [data_width_p-1:0]     mem_cmd_data_o,
   input  logic                        mem_cmd_ready_i,
   input  logic                        mem_resp_v_i,
   input  logic [data_width_p-1:0]     mem_resp_data_i,
   output logic                        mem_resp_yumi_o,
   output logic                        busy_o,
   output e_sacc_vdp_ctrl_state_e      dbg_state_o
);

   e_sacc_vdp_ctrl_state_e     state_q;
   logic [data_width_p-1:0]    acc_q, a_elem_q, cmd_data_q, acc_next;
   logic [len_width_p-1:0]     idx_q, idx_inc, len;
   logic [paddr_width_p-1:0]   cmd_addr_q, a_base, b_base, res_addr;
   logic                       cmd_v_q, cmd_w_q, resp_wait_q, start, done_set;

   function automatic logic [paddr_width_p-1:0] elem_addr(
      input logic [paddr_width_p-1:0] base,
      input logic [len_width_p-1:0]   idx
   );
      return base + (paddr_width_p'(idx) << 3);
   endfunction

   bp_sacc_vdp_csr_regfile #(
      .paddr_width_p   (paddr_width_p),
      .data_width_p    (data_width_p),
      .len_width_p     (len_width_p),
      .csr_addr_width_p(csr_addr_width_p)
   ) u_regfile (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .csr_v_i        (csr_v_i),
      .csr_w_i        (csr_w_i),
      .csr_addr_i     (csr_addr_i),
      .csr_data_i     (csr_data_i),
      .csr_ready_o    (csr_ready_o),
      .csr_resp_v_o   (csr_resp_v_o),
      .csr_resp_data_o(csr_resp_data_o),
      .csr_resp_yumi_i(csr_resp_yumi_i),
      .busy_i         (busy_o),
      .done_set_i     (done_set),
      .result_i       (acc_q),
      .a_base_o       (a_base),
      .b_base_o       (b_base),
      .len_o          (len),
      .res_addr_o     (res_addr),
      .start_o        (start)
   );

   // Product keeps only the low data_width_p bits, so the sum wraps.
   assign acc_next = acc_q + a_elem_q * mem_resp_data_i;
   assign idx_inc  = idx_q + 1'b1;
   assign done_set = (state_q == e_vdp_wt_wr) & mem_resp_v_i;

   assign mem_cmd_v_o     = cmd_v_q;
   assign mem_cmd_w_o     = cmd_w_q;
   assign mem_cmd_addr_o  = cmd_addr_q;
   assign mem_cmd_data_o  = cmd_data_q;
   assign mem_resp_yumi_o = resp_wait_q & mem_resp_v_i;
   assign busy_o          = (state_q != e_vdp_idle);
   assign dbg_state_o     = state_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= e_vdp_idle;
         acc_q       <= '0;
         a_elem_q    <= '0;
         idx_q       <= '0;
         cmd_v_q     <= 1'b0;
         cmd_w_q     <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         resp_wait_q <= 1'b0;
      end else begin
         case (state_q)
            e_vdp_idle: if (start) begin
               acc_q   <= '0;
               idx_q   <= '0;
               cmd_v_q <= 1'b1;
               if (len == '0) begin
                  state_q    <= e_vdp_wr_res;
                  cmd_w_q    <= 1'b1;
                  cmd_addr_q <= res_addr;
                  cmd_data_q <= '0;
               end else begin
                  state_q    <= e_vdp_rd_a;
                  cmd_w_q    <= 1'b0;
                  cmd_addr_q <= a_base;
               end
            end
            e_vdp_rd_a: if (mem_cmd_ready_i) begin
               cmd_v_q     <= 1'b0;
               resp_wait_q <= 1'b1;
               state_q     <= e_vdp_wt_a;
            end
            e_vdp_wt_a: if (mem_resp_v_i) begin
               a_elem_q    <= mem_resp_data_i;
               resp_wait_q <= 1'b0;
               cmd_v_q     <= 1'b1;
               cmd_w_q     <= 1'b0;
               cmd_addr_q  <= elem_addr(b_base, idx_q);
               state_q     <= e_vdp_rd_b;
            end
            e_vdp_rd_b: if (mem_cmd_ready_i) begin
               cmd_v_q     <= 1'b0;
               resp_wait_q <= 1'b1;
               state_q     <= e_vdp_wt_b;
            end
            e_vdp_wt_b: if (mem_resp_v_i) begin
               acc_q       <= acc_next;
               idx_q       <= idx_inc;
               resp_wait_q <= 1'b0;
               cmd_v_q     <= 1'b1;
               if (idx_inc == len) begin
                  state_q    <= e_vdp_wr_res;
                  cmd_w_q    <= 1'b1;
                  cmd_addr_q <= res_addr;
                  cmd_data_q <= acc_next;
               end else begin
                  state_q    <= e_vdp_rd_a;
                  cmd_w_q    <= 1'b0;
                  cmd_addr_q <= elem_addr(a_base, idx_inc);
               end
            end
            e_vdp_wr_res: if (mem_cmd_ready_i) begin
               cmd_v_q     <= 1'b0;
               resp_wait_q <= 1'b1;
               state_q     <= e_vdp_wt_wr;
            end
            e_vdp_wt_wr: if (mem_resp_v_i) begin
               resp_wait_q <= 1'b0;
               state_q     <= e_vdp_idle;
            end
            default: state_q <= e_vdp_idle;
         endcase
      end
   end

endmodule

// File: doc/bp_sacc_vdp_ctrl.md
Name: bp_sacc_vdp_ctrl

Overview:
Sequencer for the streaming vector-dot-product accelerator in the sacc tile.
- Configured through memory-mapped CSR accesses arriving from the tile's I/O CCE.
- Fetches operand vectors A and B one 64-bit element at a time over the tile's LCE-side I/O command/response channel.
- Multiply-accumulates the elements, writes the result back to memory, and reports busy/done status.

Parameters:
paddr_width_p, 40, physical address width
data_width_p, 64, element, accumulator and CSR data width
len_width_p, 16, vector length field width (elements)
csr_addr_width_p, 3, CSR index width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous, active-low reset
csr_v_i  in  1  CSR request valid
csr_w_i  in  1  1=write, 0=read
csr_addr_i  in  csr_addr_width_p  CSR index
csr_data_i  in  data_width_p  write data
csr_ready_o  out  1  CSR request accepted when csr_v_i&csr_ready_o
csr_resp_v_o  out  1  CSR response valid
csr_resp_data_o  out  data_width_p  read data (0 for writes)
csr_resp_yumi_i  in  1  CSR response consumed
mem_cmd_v_o  out  1  memory command valid
mem_cmd_w_o  out  1  1=store, 0=load (8-byte)
mem_cmd_addr_o  out  paddr_width_p  byte address
mem_cmd_data_o  out  data_width_p  store data
mem_cmd_ready_i  in  1  command accepted when v&ready
mem_resp_v_i  in  1  memory response valid
mem_resp_data_i  in  data_width_p  load data (ignored for store acks)
mem_resp_yumi_o  out  1  response consumed
busy_o  out  1  FSM not in IDLE

Behaviour:
Reset and CSR map
- Reset (async assert, sync release): FSM=IDLE. All CSRs, accumulator and index are 0. All valid outputs are 0, csr_ready_o=1, busy_o=0.
- CSR map: 0 A_BASE, 1 B_BASE, 2 LEN (low len_width_p bits), 3 RES_ADDR, 4 START (write only; read returns 0), 5 STATUS {..,done,busy}, 6 RESULT (read only), 7 unmapped (reads 0, writes dropped).

CSR handshake
- One-entry response buffer; csr_ready_o = ~csr_resp_v_o.
- An accepted request produces csr_resp_v_o the next cycle; it holds until csr_resp_yumi_i.
- A response can be consumed and a new request accepted in the same cycle only through the following cycle: ready deasserts while the response is held, giving throughput of 1 access per 2 cycles.
- Writes to 0-3 and START while busy_o=1 are acknowledged but have no effect. Reads are always serviced.
- START write in IDLE: clears done, accumulator and index, then goes to RD_A.

FSM
- States: IDLE, RD_A, WT_A, RD_B, WT_B, WR_RES, WT_WR.
- RD_A: mem_cmd_v_o=1, load, addr=A_BASE+8*idx. On handshake go to WT_A.
- WT_A: mem_resp_yumi_o=mem_resp_v_i; latch the A element and go to RD_B.
- RD_B/WT_B: same as RD_A/WT_A using B_BASE. On response, acc <= acc + A*B (low data_width_p bits of the product, wraps mod 2^64) and idx++. If idx+1==LEN go to WR_RES, else RD_A.
- LEN==0 at START: go directly to WR_RES and store 0.
- WR_RES: store acc to RES_ADDR. On handshake go to WT_WR.
- WT_WR: on response ack, RESULT<=acc, done<=1, go to IDLE.
- mem_cmd_* fields are stable while mem_cmd_v_o=1 and not yet accepted.
- mem_resp_yumi_o is 0 in every non-WT state; stray responses are not consumed.
- Addresses wrap modulo 2^paddr_width_p.
- Minimum per-element latency: 4 cycles (zero-wait memory).
- Async reset mid-operation aborts immediately. Outstanding memory responses after reset are the environment's responsibility.

Decomposition:
- bp_common_pkg gets a bp_sacc_vdp_csr_e enum (the seven CSR indices) and e_sacc_vdp_ctrl_state_e.
- One sub-module: bp_sacc_vdp_csr_regfile (CSR storage, response buffer, busy-gated write enables). FSM and MAC stay in the top.

Test Plan:
- Reset: assert reset_n_i=0 mid-RD_B → next cycle busy_o=0, mem_cmd_v_o=0, csr_ready_o=1. Reading STATUS then returns 0.
- Basic: A_BASE=0x1000 holding {1,2,3}, B_BASE=0x2000 holding {4,5,6}, LEN=3, RES_ADDR=0x3000, START → loads 0x1000,0x2000,0x1008,0x2008,0x1010,0x2010 in order, then store 32 to 0x3000. RESULT=32, STATUS=0b10.
- LEN=0, START → no loads, one store of 0 to RES_ADDR, done=1.
- Overflow: A={0xFFFF_FFFF_FFFF_FFFF}, B={2}, LEN=1 → RESULT=0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: hold mem_cmd_ready_i=0 for 5 cycles in RD_A → addr/v stable all 5 cycles, exactly one load issued. Delay each response 3 cycles → RESULT unchanged versus zero-wait.
- Busy protection: during the run write LEN=9 and START, and hold csr_resp_yumi_i=0 for 4 cycles → acks delivered, csr_ready_o=0 while held, LEN reads back 3, exactly one result store.
